// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and constants for the serial pattern transmitter
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } seq_state_t;

  localparam logic [3:0] DEF_PATTERN = 4'b1010;

endpackage

// File: rtl/seq_piso.sv
// rtl/seq_piso.sv - parallel-in/serial-out shift register, MSB first
module seq_piso #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         msb
);

  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/seq_gen_tx.sv
// rtl/seq_gen_tx.sv - serial pattern transmitter: repeats a captured pattern MSB-first
// with optional idle gap slots between repetitions, one slot per bit_en strobe.
module seq_gen_tx
  import seq_pkg::*;
#(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 4,
  parameter int   GAP_BITS = 0,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic             bit_en,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(PAT_W);
  localparam int GAP_W = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  seq_state_t       state;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] reps_left;
  logic [BIT_W-1:0] bit_idx;
  logic [GAP_W-1:0] gap_cnt;

  logic             accept, send_step, last_bit, more_reps, gap_end;
  logic             piso_load, piso_shift, piso_msb;
  logic [PAT_W-1:0] piso_d;

  // The shift register holds only the bits still to come after the one on
  // ser_out, so its MSB is always the next bit to present.
  always_comb begin
    accept     = (state == IDLE) && start && !abort;
    send_step  = (state == SEND) && bit_en && !abort;
    last_bit   = (bit_idx == LAST_BIT);
    more_reps  = (reps_left > CNT_W'(1));
    gap_end    = (state == GAP) && bit_en && !abort && (gap_cnt == LAST_GAP);
    piso_load  = accept || (send_step && last_bit && more_reps && (GAP_BITS == 0)) || gap_end;
    piso_shift = send_step && !last_bit;
    piso_d     = accept ? {pattern[PAT_W-2:0], 1'b0} : {pat_q[PAT_W-2:0], 1'b0};
  end

  seq_piso #(.W(PAT_W)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (piso_load),
    .shift (piso_shift),
    .d     (piso_d),
    .msb   (piso_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pat_q     <= '0;
      reps_left <= '0;
      bit_idx   <= '0;
      gap_cnt   <= '0;
      ser_out   <= IDLE_LVL;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pat_q     <= pattern;
            reps_left <= (rep_cnt == '0) ? CNT_W'(1) : rep_cnt;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            ser_out   <= pattern[PAT_W-1];
            ser_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            state     <= IDLE;
            ser_out   <= IDLE_LVL;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (bit_en) begin
            if (!last_bit) begin
              bit_idx <= bit_idx + BIT_W'(1);
              ser_out <= piso_msb;
            end else if (more_reps) begin
              reps_left <= reps_left - CNT_W'(1);
              bit_idx   <= '0;
              if (GAP_BITS > 0) begin
                state     <= GAP;
                gap_cnt   <= '0;
                ser_out   <= IDLE_LVL;
                ser_valid <= 1'b0;
              end else begin
                ser_out <= pat_q[PAT_W-1];
              end
            end else begin
              state     <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              ser_valid <= 1'b0;
              ser_out   <= IDLE_LVL;
            end
          end
        end
        GAP: begin
          if (abort) begin
            state     <= IDLE;
            ser_out   <= IDLE_LVL;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (bit_en) begin
            if (gap_cnt == LAST_GAP) begin
              state     <= SEND;
              gap_cnt   <= '0;
              ser_out   <= pat_q[PAT_W-1];
              ser_valid <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen_tx.sv
// tb/tb_seq_gen_tx.sv - self-checking bench for seq_gen_tx (back-to-back and gapped instances)
module tb_seq_gen_tx;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pattern = DEF_PATTERN;
  logic [3:0] rep_cnt = 4'd1;
  logic       bit_en = 1'b1;
  logic       abort = 1'b0;

  logic ser_out0, ser_valid0, busy0, done0;
  logic ser_out2, ser_valid2, busy2, done2;
  logic [3:0] o0, o2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_gen_tx #(.PAT_W(4), .CNT_W(4), .GAP_BITS(0), .IDLE_LVL(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .rep_cnt(rep_cnt),
    .bit_en(bit_en), .abort(abort),
    .ser_out(ser_out0), .ser_valid(ser_valid0), .busy(busy0), .done(done0)
  );

  seq_gen_tx #(.PAT_W(4), .CNT_W(4), .GAP_BITS(2), .IDLE_LVL(1'b0)) dut_g (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .rep_cnt(rep_cnt),
    .bit_en(bit_en), .abort(abort),
    .ser_out(ser_out2), .ser_valid(ser_valid2), .busy(busy2), .done(done2)
  );

  // Packed as {ser_out, ser_valid, busy, done}
  assign o0 = {ser_out0, ser_valid0, busy0, done0};
  assign o2 = {ser_out2, ser_valid2, busy2, done2};

  typedef struct {
    logic [3:0]  pat;
    logic [3:0]  reps;
    int          nbits;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[5];

  // Reference model state, one slot per instance (index 0: no gap, 1: gap of 2)
  int         gaps[2];
  logic       m_active[2];
  logic       m_done[2];
  int         m_pos[2];
  int         m_reps[2];
  logic [3:0] m_pat[2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {out,valid,busy,done}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic settle();
    start  = 1'b0;
    abort  = 1'b0;
    bit_en = 1'b1;
    repeat (24) step();
  endtask

  function automatic logic [3:0] model_out(input int m);
    int r;
    logic b;
    if (m_done[m]) return 4'b0001;
    if (!m_active[m]) return 4'b0000;
    r = m_pos[m] % (4 + gaps[m]);
    if (r < 4) begin
      b = m_pat[m][3-r];
      return {b, 3'b110};
    end
    return 4'b0010;
  endfunction

  task automatic model_update(input int m);
    int slots;
    slots = m_reps[m] * 4 + (m_reps[m] - 1) * gaps[m];
    if (m_done[m]) begin
      m_done[m] = 1'b0;
    end else if (m_active[m]) begin
      if (abort) begin
        m_active[m] = 1'b0;
      end else if (bit_en) begin
        m_pos[m]++;
        if (m_pos[m] == slots) begin
          m_active[m] = 1'b0;
          m_done[m]   = 1'b1;
        end
      end
    end else if (start && !abort) begin
      m_active[m] = 1'b1;
      m_pos[m]    = 0;
      m_pat[m]    = pattern;
      m_reps[m]   = (rep_cnt == 4'd0) ? 1 : int'(rep_cnt);
    end
  endtask

  initial begin
    logic [9:0] g_out, g_val;

    vecs[0] = '{4'b1010, 4'd1, 4,  16'h000A};
    vecs[1] = '{4'b1010, 4'd3, 12, 16'h0AAA};
    vecs[2] = '{4'b1010, 4'd0, 4,  16'h000A};
    vecs[3] = '{4'b1100, 4'd2, 8,  16'h00CC};
    vecs[4] = '{4'b0001, 4'd1, 4,  16'h0001};
    gaps[0] = 0;
    gaps[1] = 2;

    step();
    step();
    chk("reset_dut", o0, 4'b0000);
    chk("reset_gap", o2, 4'b0000);
    rst = 1'b0;

    // Table: back-to-back repetitions on the no-gap instance
    for (int i = 0; i < 5; i++) begin
      settle();
      start = 1'b1; pattern = vecs[i].pat; rep_cnt = vecs[i].reps;
      step();
      start = 1'b0;
      for (int c = 1; c <= vecs[i].nbits; c++) begin
        chk($sformatf("vec%0d_c%0d", i, c), o0, {vecs[i].exp[vecs[i].nbits-c], 3'b110});
        step();
      end
      chk($sformatf("vec%0d_done", i), o0, 4'b0001);
      step();
      chk($sformatf("vec%0d_after", i), o0, 4'b0000);
    end

    // Gapped repetitions: 1010, two idle slots, 1010, done
    settle();
    g_out = 10'b1010001010;
    g_val = 10'b1111001111;
    start = 1'b1; pattern = 4'b1010; rep_cnt = 4'd2;
    step();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("gap_c%0d", c), o2, {g_out[10-c], g_val[10-c], 2'b10});
      step();
    end
    chk("gap_done", o2, 4'b0001);

    // Strobe every third cycle, pattern 1100
    settle();
    bit_en = 1'b0;
    start = 1'b1; pattern = 4'b1100; rep_cnt = 4'd1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      bit_en = ((c % 3) == 2);
      chk($sformatf("strobe_c%0d", c), o0, {(c <= 5) ? 1'b1 : 1'b0, 3'b110});
      step();
    end
    bit_en = 1'b1;
    chk("strobe_done", o0, 4'b0001);

    // Abort mid-transfer, then restart immediately
    settle();
    start = 1'b1; pattern = 4'b1010; rep_cnt = 4'd1;
    step();
    start = 1'b0;
    chk("abort_c1", o0, 4'b1110);
    step();
    abort = 1'b1;
    chk("abort_c2", o0, 4'b0110);
    step();
    abort = 1'b0;
    chk("abort_c3", o0, 4'b0000);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_c4", o0, 4'b1110);
    step(); chk("restart_c5", o0, 4'b0110);
    step(); chk("restart_c6", o0, 4'b1110);
    step(); chk("restart_c7", o0, 4'b0110);
    step(); chk("restart_done", o0, 4'b0001);

    // Abort wins over start in IDLE
    settle();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", o0, 4'b0000);
    step();
    chk("abort_start_idle2", o0, 4'b0000);

    // start during the DONE cycle is ignored, accepted one cycle later
    settle();
    start = 1'b1; pattern = 4'b1010; rep_cnt = 4'd1;
    step();
    start = 1'b0;
    repeat (4) step();
    start = 1'b1; pattern = 4'b0110;
    chk("done_start_c5", o0, 4'b0001);
    step();
    chk("done_start_c6", o0, 4'b0000);
    step();
    start = 1'b0;
    chk("done_start_c7", o0, 4'b0110);

    // Re-start while busy is ignored; reset mid-transfer
    settle();
    start = 1'b1; pattern = 4'b1010; rep_cnt = 4'd1;
    step();
    start = 1'b0;
    chk("busy_start_c1", o0, 4'b1110);
    step();
    start = 1'b1; pattern = 4'b0110;
    chk("busy_start_c2", o0, 4'b0110);
    step();
    start = 1'b0;
    chk("busy_start_c3", o0, 4'b1110);
    rst = 1'b1;
    step();
    chk("rst_mid_dut", o0, 4'b0000);
    chk("rst_mid_gap", o2, 4'b0000);
    rst = 1'b0;

    // Randomized traffic against the slot-level model
    for (int m = 0; m < 2; m++) begin
      m_active[m] = 1'b0; m_done[m] = 1'b0; m_pos[m] = 0; m_reps[m] = 1; m_pat[m] = 4'b0;
    end
    for (int n = 0; n < 3000; n++) begin
      chk($sformatf("rand%0d_dut", n), o0, model_out(0));
      chk($sformatf("rand%0d_gap", n), o2, model_out(1));
      start   = ($urandom_range(0, 3) == 0);
      pattern = 4'($urandom_range(0, 15));
      rep_cnt = 4'($urandom_range(0, 15));
      bit_en  = ($urandom_range(0, 1) == 1);
      abort   = ($urandom_range(0, 39) == 0);
      model_update(0);
      model_update(1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
